// File: rtl/crubits_bank.sv
// crubits_bank: TI-99/4A CRU output-bit bank with synchronised strobe, write pulses and read-back
module crubits_bank #(
    parameter int NUM_BITS = 8,
    parameter logic [0:NUM_BITS-1] RESET_VALUE = '0,
    parameter logic [0:NUM_BITS-1] RB_SEL = '0
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [0:3]          cru_base,
    input  logic                cru_clk,
    input  logic [0:14]         addr,
    input  logic                ti_cru_out,
    input  logic [0:NUM_BITS-1] status_in,
    output logic [0:NUM_BITS-1] bits,
    output logic [0:NUM_BITS-1] bit_wr,
    output logic                ti_cru_in,
    output logic                cru_in_oe
);
    localparam logic [7:0] NB = 8'(NUM_BITS);
    logic [6:0] idx;
    logic hit;
    logic s1, s2, s3, fall_q;
    logic h_hit, h_data;
    logic [6:0] h_idx;
    logic [0:NUM_BITS-1] wr_vec;
    logic rd;
    assign idx = addr[8:14];
    assign hit = addr[0:3] == 4'b0001 && addr[4:7] == cru_base && {1'b0, idx} < NB;
    assign ti_cru_in = hit & rd;
    assign cru_in_oe = hit;
    always_comb begin
        wr_vec = '0;
        rd = 1'b0;
        for (int i = 0; i < NUM_BITS; i++) begin
            wr_vec[i] = fall_q && h_hit && h_idx == 7'(i);
            if (idx == 7'(i)) rd = RB_SEL[i] ? status_in[i] : bits[i];
        end
    end
    // hold registers track the bus only while the synchronised strobe is high
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
            fall_q <= 1'b0;
            h_hit <= 1'b0;
            h_idx <= '0;
            h_data <= 1'b0;
            bits <= RESET_VALUE;
            bit_wr <= '0;
        end else begin
            s1 <= cru_clk;
            s2 <= s1;
            s3 <= s2;
            fall_q <= s3 & ~s2;
            if (s2) begin
                h_hit <= hit;
                h_idx <= idx;
                h_data <= ti_cru_out;
            end
            bits <= (bits & ~wr_vec) | (wr_vec & {NUM_BITS{h_data}});
            bit_wr <= wr_vec;
        end
    end
endmodule
